// File: rtl/instr_encode_loader_if.sv
// Request and imem-write bundle for instr_encode_loader.
// master drives requests and imem_ready; slave is the loader.
interface instr_encode_loader_if #(
  parameter int ADDR_W = 6
) ();
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [12:0]       req_imm;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output req_valid, req_op, req_rd,
    output req_rs1, req_rs2, req_imm,
    input  req_ready,
    input  imem_we, imem_addr, imem_wdata,
    output imem_ready
  );

  modport slave (
    input  req_valid, req_op, req_rd,
    input  req_rs1, req_rs2, req_imm,
    output req_ready,
    output imem_we, imem_addr, imem_wdata,
    input  imem_ready
  );
endinterface

// File: rtl/instr_encode_loader.sv
// RV32I request encoder with FIFO drain into imem at sequential addresses.
// INSTR_ENC_ILLEGAL_TRAP_EN: illegal ops set err and end the load early.
module instr_encode_loader #(
  parameter int ADDR_W     = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  instr_encode_loader_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_LW   = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_BEQ  = 3'd5;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } state_t;

  state_t            state_q;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wptr_q;
  logic [PW-1:0]     rptr_q;
  logic [PW:0]       cnt_q;
  logic [PW:0]       cnt_d;
  logic [ADDR_W:0]   acc_q;
  logic [ADDR_W-1:0] addr_q;
  logic              done_q;
  logic              err_q;

  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        fire;
  logic        acc_ok;
  logic        last_acc;
  logic [31:0] word;

  logic [2:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [12:0] imm;

  assign op  = bus.req_op;
  assign rd  = bus.req_rd;
  assign rs1 = bus.req_rs1;
  assign rs2 = bus.req_rs2;
  assign imm = bus.req_imm;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign acc_ok   = !acc_q[ADDR_W];
  assign last_acc = (acc_q == (ADDR_W+1)'((1 << ADDR_W) - 1));
  assign pop      = !empty && bus.imem_ready;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign bus.req_ready = (state_q == LOAD) && acc_ok
                       && (!full || pop);
  assign fire = bus.req_valid && bus.req_ready;

`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
  logic illegal;
  assign illegal = (op[2:1] == 2'b11);
  assign push    = fire && !illegal;
`else
  assign push    = fire;
`endif

  assign cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);

  always_comb begin
    word = NOP;
    unique case (1'b1)
      (op == OP_ADD):
        word = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_R};
      (op == OP_SUB):
        word = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_R};
      (op == OP_ADDI):
        word = {imm[11:0], rs1, 3'b000, rd, OPC_I};
      (op == OP_LW):
        word = {imm[11:0], rs1, 3'b010, rd, OPC_LD};
      (op == OP_SW):
        word = {imm[11:5], rs2, rs1, 3'b010,
                imm[4:0], OPC_ST};
      (op == OP_BEQ):
        word = {imm[12], imm[10:5], rs2, rs1, 3'b000,
                imm[4:1], imm[11], OPC_BR};
      default:
        word = NOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      addr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        mem_q[wptr_q] <= word;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      if (state_q == IDLE && start) begin
        addr_q <= '0;
      end else if (pop) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            acc_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        LOAD: begin
          if (fire) begin
            acc_q <= acc_q + (ADDR_W+1)'(1);
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
            if (illegal) begin
              err_q   <= 1'b1;
              state_q <= DRAIN;
            end else if (last_acc) begin
              state_q <= DRAIN;
            end
`else
            if (last_acc) begin
              state_q <= DRAIN;
            end
`endif
          end
        end
        DRAIN: begin
          if (cnt_d == '0) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.imem_we    = !empty;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = empty ? 32'h0 : mem_q[rptr_q];

  assign busy = (state_q != IDLE) || !empty;
  assign done = done_q;
  assign err  = err_q;
endmodule
